// File: rtl/io_uart_pkg.sv
// Shared definitions for the IO-page UART: status bit positions, FSM encodings,
// and the bit-period helper.
package io_uart_pkg;

  localparam int unsigned CntlRxv  = 0;
  localparam int unsigned CntlTxf  = 1;
  localparam int unsigned CntlTxo  = 2;
  localparam int unsigned CntlRxo  = 3;
  localparam int unsigned CntlFrm  = 4;
  localparam int unsigned CntlBusy = 9;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop on empty is ignored and a push
// on full is accepted only when a pop frees a slot in the same cycle.
module io_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign o_empty = (wptr_q == rptr_q);
  assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);
  assign o_head  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/io_uart_fifo.sv
// Memory-mapped UART with TX/RX FIFOs, sticky W1C error flags and an
// RX-available interrupt.
module io_uart_fifo
  import io_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 16,
  parameter int unsigned DAT_BIT     = 1,
  parameter int unsigned CNTL_BIT    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic [29:0] i_wordaddr,
  input  logic        i_wstrb,
  input  logic        i_rstrb,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned CW  = $clog2(CPB);
  localparam logic [CW-1:0] BitEnd  = CW'(CPB - 1);
  localparam logic [CW-1:0] HalfEnd = CW'(CPB / 2 - 1);

  logic       dat_sel, cntl_sel, tx_busy;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_head, rx_head;
  logic       frm_set, unused_bits;

  tx_state_e  tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_q, tx_d;

  rx_state_e  rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_s1_q, rx_s2_q, rx_s3_q;

  logic       txo_q, txo_d, rxo_q, rxo_d, frm_q, frm_d, irq_q, irq_d;

  assign dat_sel     = i_sel & i_wordaddr[DAT_BIT];
  assign cntl_sel    = i_sel & i_wordaddr[CNTL_BIT];
  assign tx_push     = dat_sel & i_wstrb;
  assign rx_pop      = dat_sel & i_rstrb;
  assign tx_busy     = ~tx_empty | (tx_state_q != TxIdle);
  assign unused_bits = ^{i_wordaddr, i_wdata[31:8]};
  assign o_tx        = tx_q;
  assign o_irq       = irq_q;

  io_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (tx_push),
    .i_pop   (tx_pop),
    .i_wdata (i_wdata[7:0]),
    .o_head  (tx_head),
    .o_full  (tx_full),
    .o_empty (tx_empty)
  );

  io_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (rx_push),
    .i_pop   (rx_pop),
    .i_wdata (rx_shift_q),
    .o_head  (rx_head),
    .o_full  (rx_full),
    .o_empty (rx_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = TxStart;
          tx_shift_d = tx_head;
          tx_d       = 1'b0;
        end
      end
      TxStart: if (tx_cnt_q == BitEnd) begin
        tx_state_d = TxData;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
        tx_shift_d = tx_shift_q >> 1;
      end
      TxData: if (tx_cnt_q == BitEnd) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TxStop;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      TxStop: if (tx_cnt_q == BitEnd) tx_state_d = TxIdle;
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    frm_set    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_s3_q && !rx_s2_q) rx_state_d = RxStart;
      end
      RxStart: if (rx_cnt_q == HalfEnd) begin
        // Line back high at mid-start means a glitch, not a frame.
        rx_state_d = rx_s2_q ? RxIdle : RxData;
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
      end
      RxData: if (rx_cnt_q == BitEnd) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        else rx_bit_d = rx_bit_q + 1'b1;
      end
      RxStop: if (rx_cnt_q == BitEnd) begin
        if (rx_s2_q) begin
          rx_push    = 1'b1;
          rx_state_d = RxIdle;
        end else begin
          frm_set    = 1'b1;
          rx_state_d = RxWait;
        end
      end
      RxWait: if (rx_s2_q) rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  // Set beats clear when both land in the same cycle.
  always_comb begin
    txo_d = (txo_q & ~(cntl_sel & i_wstrb & i_wdata[CntlTxo])) |
            (tx_push & tx_full & ~tx_pop);
    rxo_d = (rxo_q & ~(cntl_sel & i_wstrb & i_wdata[CntlRxo])) |
            (rx_push & rx_full & ~rx_pop);
    frm_d = (frm_q & ~(cntl_sel & i_wstrb & i_wdata[CntlFrm])) | frm_set;
    irq_d = ~rx_empty;
  end

  always_comb begin
    o_rdata = '0;
    if (dat_sel) begin
      if (!rx_empty) o_rdata = {23'b0, 1'b1, rx_head};
    end else if (cntl_sel) begin
      o_rdata[CntlBusy] = tx_busy;
      o_rdata[CntlFrm]  = frm_q;
      o_rdata[CntlRxo]  = rxo_q;
      o_rdata[CntlTxo]  = txo_q;
      o_rdata[CntlTxf]  = tx_full;
      o_rdata[CntlRxv]  = ~rx_empty;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      txo_q      <= 1'b0;
      rxo_q      <= 1'b0;
      frm_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= i_rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      txo_q      <= txo_d;
      rxo_q      <= rxo_d;
      frm_q      <= frm_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_io_uart_fifo.sv
// Directed bench for io_uart_fifo at 10 clocks per bit, TX depth 4, RX depth 2.
module tb_io_uart_fifo;

  localparam int unsigned DatBit  = 1;
  localparam int unsigned CntlBit = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [29:0] wordaddr;
  logic        wstrb;
  logic        rstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rx;
  logic        tx;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [7:0]  tx_seen [$];
  int          tx_bad = 0;
  logic [7:0]  mon_b;
  logic        mon_s0, mon_sp;
  logic [31:0] d;
  logic [7:0]  v;

  io_uart_fifo #(
    .CLK_FREQ_HZ (1000),
    .BAUD_RATE   (100),
    .TX_DEPTH    (4),
    .RX_DEPTH    (2),
    .DAT_BIT     (DatBit),
    .CNTL_BIT    (CntlBit)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sel      (sel),
    .i_wordaddr (wordaddr),
    .i_wstrb    (wstrb),
    .i_rstrb    (rstrb),
    .i_wdata    (wdata),
    .o_rdata    (rdata),
    .i_rx       (rx),
    .o_tx       (tx),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  // Serial decoder on o_tx, sampling mid-bit on falling clock edges.
  initial forever begin
    @(negedge tx);
    repeat (5) @(negedge clk);
    mon_s0 = tx;
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      mon_b[i] = tx;
    end
    repeat (10) @(negedge clk);
    mon_sp = tx;
    if (!mon_s0 && mon_sp) tx_seen.push_back(mon_b);
    else tx_bad++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic peek(input int unsigned b, output logic [31:0] q);
    sel = 1'b1;
    wordaddr = '0;
    wordaddr[b] = 1'b1;
    #1;
    q = rdata;
    sel = 1'b0;
    wordaddr = '0;
  endtask

  task automatic wr(input int unsigned b, input logic [31:0] x);
    sel = 1'b1;
    wordaddr = '0;
    wordaddr[b] = 1'b1;
    wstrb = 1'b1;
    wdata = x;
    tick();
    sel = 1'b0;
    wordaddr = '0;
    wstrb = 1'b0;
    wdata = '0;
  endtask

  task automatic pop();
    sel = 1'b1;
    wordaddr = '0;
    wordaddr[DatBit] = 1'b1;
    rstrb = 1'b1;
    tick();
    sel = 1'b0;
    wordaddr = '0;
    rstrb = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(10);
    end
    rx = stop;
    tick(10);
    rx = 1'b1;
    if (!stop) tick(10);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; wordaddr = '0; wstrb = 1'b0; rstrb = 1'b0;
    wdata = '0; rx = 1'b1;
    tick(3);
    rst = 1'b0;
    chk("reset_tx", tx, 1);
    chk("reset_irq", irq, 0);
    peek(CntlBit, d); chk("reset_cntl", d, 32'h0);
    peek(DatBit, d);  chk("reset_data", d, 32'h0);

    // Single TX of 0x55 with cycle-exact line checks
    v = 8'h55;
    wr(DatBit, 32'h55);
    chk("tx1_idle_at_push", tx, 1);
    tick();
    chk("tx1_start_edge", tx, 0);
    tick(5);
    chk("tx1_start_mid", tx, 0);
    for (int i = 0; i < 8; i++) begin
      tick(10);
      chk($sformatf("tx1_bit%0d", i), tx, {31'b0, v[i]});
    end
    peek(CntlBit, d); chk("tx1_busy", d, 32'h200);
    tick(10);
    chk("tx1_stop", tx, 1);
    tick(6);
    peek(CntlBit, d); chk("tx1_done_cntl", d, 32'h0);
    chk("tx1_count", tx_seen.size(), 1);
    chk("tx1_byte", tx_seen[0], 32'h55);
    tx_seen.delete();

    // Burst of six into a four-deep FIFO: sixth byte drops
    for (int b = 1; b <= 6; b++) wr(DatBit, b);
    peek(CntlBit, d); chk("burst_full_ovf", d, 32'h206);
    tick(100);
    peek(CntlBit, d); chk("burst_ovf_busy", d, 32'h204);
    wr(CntlBit, 32'h4);
    peek(CntlBit, d); chk("burst_ovf_clr", d, 32'h200);
    tick(500);
    chk("burst_count", tx_seen.size(), 5);
    for (int b = 0; b < 5; b++) chk($sformatf("burst_byte%0d", b), tx_seen[b], b + 1);
    peek(CntlBit, d); chk("burst_idle", d, 32'h0);
    tx_seen.delete();

    // Deselected write has no effect and reads zero
    sel = 1'b0; wordaddr = '0; wordaddr[DatBit] = 1'b1; wstrb = 1'b1; wdata = 32'h99;
    #1;
    chk("nosel_rdata", rdata, 32'h0);
    tick();
    wordaddr = '0; wstrb = 1'b0; wdata = '0;
    tick(3);
    peek(CntlBit, d); chk("nosel_cntl", d, 32'h0);
    chk("nosel_tx", tx, 1);

    // RX of 0xA3
    send_rx(8'hA3, 1'b1);
    tick(2);
    chk("rx1_irq", irq, 1);
    peek(CntlBit, d); chk("rx1_cntl", d, 32'h1);
    peek(DatBit, d);  chk("rx1_data", d, 32'h1A3);
    pop();
    peek(DatBit, d);  chk("rx1_empty", d, 32'h0);
    tick();
    chk("rx1_irq_low", irq, 0);

    // Framing error then a good byte
    send_rx(8'h3C, 1'b0);
    tick(3);
    peek(CntlBit, d); chk("frm_cntl", d, 32'h10);
    chk("frm_irq", irq, 0);
    send_rx(8'h7E, 1'b1);
    tick(2);
    peek(DatBit, d);  chk("frm_next_data", d, 32'h17E);
    pop();
    wr(CntlBit, 32'h10);
    peek(CntlBit, d); chk("frm_clr", d, 32'h0);

    // RX overflow with a two-deep FIFO
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    send_rx(8'h33, 1'b1);
    tick(2);
    peek(CntlBit, d); chk("rxo_cntl", d, 32'h9);
    peek(DatBit, d);  chk("rxo_first", d, 32'h111);
    pop();
    peek(DatBit, d);  chk("rxo_second", d, 32'h122);
    pop();
    peek(DatBit, d);  chk("rxo_empty", d, 32'h0);
    wr(CntlBit, 32'h8);
    tick();

    // Reset during data bit 3 of a frame
    wr(DatBit, 32'hA5);
    tick();
    chk("rst_frame_started", tx, 0);
    tick(45);
    rst = 1'b1;
    tick();
    chk("rst_tx_high", tx, 1);
    peek(CntlBit, d); chk("rst_cntl", d, 32'h0);
    rst = 1'b0;
    peek(DatBit, d);  chk("rst_data", d, 32'h0);
    chk("rst_irq", irq, 0);
    tick(110);
    tx_seen.delete();
    tx_bad = 0;
    wr(DatBit, 32'h3A);
    peek(CntlBit, d); chk("rst_new_busy", d, 32'h200);
    tick(110);
    chk("rst_new_count", tx_seen.size(), 1);
    chk("rst_new_byte", tx_seen[0], 32'h3A);
    chk("rst_new_frames_ok", tx_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
